// File: rtl/eth_rx_pkg.sv
// Shared types for the RX byte-to-word packer: FSM states, buffered word layout, lane keep helper.
package eth_rx_pkg;

    typedef enum logic [1:0] {SYNC, IDLE, PACK, DROP} rx_pack_state_t;

    typedef struct packed {
        logic [31:0] tdata;
        logic [3:0]  tkeep;
        logic        tlast;
        logic        tuser;
    } rx_word_t;

    // Errored zero-length beat that closes a frame truncated by overflow.
    localparam rx_word_t TERM_WORD = '{tdata: 32'h0, tkeep: 4'h0, tlast: 1'b1, tuser: 1'b1};

    function automatic logic [3:0] keep_from_idx(input logic [1:0] idx);
        logic [3:0] keep;
        case (idx)
            2'd0:    keep = 4'h1;
            2'd1:    keep = 4'h3;
            2'd2:    keep = 4'h7;
            default: keep = 4'hF;
        endcase
        return keep;
    endfunction

endpackage

// File: rtl/eth_rx_word_buf.sv
// Small synchronous FIFO of packed RX words; head is presented combinationally from storage.
module eth_rx_word_buf
    import eth_rx_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  logic     push_i,
    input  logic     pop_i,
    input  rx_word_t din_i,
    output rx_word_t head_o,
    output logic     full_o,
    output logic     empty_o
);
    localparam int AW = $clog2(DEPTH);

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    logic [AW:0] wr_q;
    logic [AW:0] rd_q;
    logic [AW:0] count;
    rx_word_t    mem_q [DEPTH];

    assign count   = wr_q - rd_q;
    assign full_o  = (count == (AW+1)'(DEPTH));
    assign empty_o = (wr_q == rd_q);
    assign head_o  = mem_q[rd_q[AW-1:0]];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_q <= '0;
            rd_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push_i && !full_o) begin
                mem_q[wr_q[AW-1:0]] <= din_i;
                wr_q                <= wr_q + 1'b1;
            end
            if (pop_i && !empty_o) begin
                rd_q <= rd_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/eth_rx_word_packer.sv
// Packs the unstallable RX MAC byte stream into 32-bit AXI-Stream words, buffering a few
// words against tready gaps and closing overflow-truncated frames with an errored terminator.
module eth_rx_word_packer
    import eth_rx_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic [7:0]       s_rx_data,
    input  logic             s_rx_valid,
    input  logic             s_rx_last,
    input  logic             s_rx_err,
    output logic [31:0]      m_axis_tdata,
    output logic [3:0]       m_axis_tkeep,
    output logic             m_axis_tlast,
    output logic             m_axis_tuser,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic [CNT_W-1:0] overflow_cnt
);
    rx_pack_state_t state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [31:0]      lanes_q, lanes_d;
    logic             term_pend_q, term_pend_d;
    logic [CNT_W-1:0] ovf_q, ovf_d;

    logic        buf_push, buf_pop, buf_full, buf_empty;
    rx_word_t    buf_din, buf_head;
    logic        data_push, overflow;
    logic [31:0] cur_data;

    eth_rx_word_buf #(.DEPTH(DEPTH)) u_buf (
        .clk_i  (aclk),
        .rst_i  (areset),
        .push_i (buf_push),
        .pop_i  (buf_pop),
        .din_i  (buf_din),
        .head_o (buf_head),
        .full_o (buf_full),
        .empty_o(buf_empty)
    );

    // Lanes are cleared after every word, so OR-ing in the new byte is enough.
    assign cur_data = lanes_q | (32'(s_rx_data) << {idx_q, 3'b000});

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        lanes_d     = lanes_q;
        term_pend_d = term_pend_q;
        ovf_d       = ovf_q;
        data_push   = 1'b0;
        overflow    = 1'b0;
        buf_push    = 1'b0;
        buf_din     = TERM_WORD;

        if (s_rx_valid) begin
            case (state_q)
                SYNC: if (s_rx_last) state_d = IDLE;
                IDLE, PACK: begin
                    if (s_rx_last || idx_q == 2'd3) begin
                        idx_d   = 2'd0;
                        lanes_d = '0;
                        // A pending terminator must precede any new frame data.
                        if (buf_full || term_pend_q) begin
                            overflow    = 1'b1;
                            term_pend_d = 1'b1;
                            if (ovf_q != {CNT_W{1'b1}}) ovf_d = ovf_q + CNT_W'(1);
                            state_d = s_rx_last ? IDLE : DROP;
                        end else begin
                            data_push = 1'b1;
                            buf_push  = 1'b1;
                            buf_din   = '{tdata: cur_data, tkeep: keep_from_idx(idx_q),
                                          tlast: s_rx_last, tuser: s_rx_err & s_rx_last};
                            state_d   = s_rx_last ? IDLE : PACK;
                        end
                    end else begin
                        lanes_d = cur_data;
                        idx_d   = idx_q + 2'd1;
                        state_d = PACK;
                    end
                end
                DROP: if (s_rx_last) state_d = IDLE;
                default: state_d = SYNC;
            endcase
        end

        if (term_pend_q && !buf_full && !data_push) begin
            buf_push = 1'b1;
            buf_din  = TERM_WORD;
            if (!overflow) term_pend_d = 1'b0;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q     <= SYNC;
            idx_q       <= 2'd0;
            lanes_q     <= '0;
            term_pend_q <= 1'b0;
            ovf_q       <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            lanes_q     <= lanes_d;
            term_pend_q <= term_pend_d;
            ovf_q       <= ovf_d;
        end
    end

    assign buf_pop       = m_axis_tvalid & m_axis_tready;
    assign m_axis_tvalid = !buf_empty;
    assign m_axis_tdata  = buf_head.tdata;
    assign m_axis_tkeep  = buf_head.tkeep;
    assign m_axis_tlast  = buf_head.tlast;
    assign m_axis_tuser  = buf_head.tuser;
    assign overflow_cnt  = ovf_q;

endmodule

// File: tb/tb_eth_rx_word_packer.sv
// Self-checking bench for eth_rx_word_packer: byte driver, expected-word queue, beat monitor.
module tb_eth_rx_word_packer;
  localparam int DEPTH = 4;
  localparam int CNT_W = 16;

  logic             aclk;
  logic             areset;
  logic [7:0]       s_rx_data;
  logic             s_rx_valid;
  logic             s_rx_last;
  logic             s_rx_err;
  logic [31:0]      m_axis_tdata;
  logic [3:0]       m_axis_tkeep;
  logic             m_axis_tlast;
  logic             m_axis_tuser;
  logic             m_axis_tvalid;
  logic             m_axis_tready;
  logic [CNT_W-1:0] overflow_cnt;

  eth_rx_word_packer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .aclk         (aclk),
    .areset       (areset),
    .s_rx_data    (s_rx_data),
    .s_rx_valid   (s_rx_valid),
    .s_rx_last    (s_rx_last),
    .s_rx_err     (s_rx_err),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tkeep (m_axis_tkeep),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tuser (m_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .overflow_cnt (overflow_cnt)
  );

  // clock / reset
  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // scoreboard state; beat layout is {tdata, tkeep, tlast, tuser}
  logic [37:0] exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [7:0]  frame_buf[64];
  bit          expect_en = 1'b0;
  bit          tog_en    = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks: inputs change 2 time units after the active edge
  task automatic send_byte(input logic [7:0] d, input logic l, input logic e);
    @(posedge aclk);
    #2;
    s_rx_valid = 1'b1;
    s_rx_data  = d;
    s_rx_last  = l;
    s_rx_err   = e;
    if (tog_en) m_axis_tready = ~m_axis_tready;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge aclk);
      #2;
      s_rx_valid = 1'b0;
      s_rx_data  = 8'h00;
      s_rx_last  = 1'b0;
      s_rx_err   = 1'b0;
      if (tog_en) m_axis_tready = ~m_axis_tready;
    end
  endtask

  // Sends frame_buf[0..len-1]; when expect_en, models the byte-to-word packing.
  task automatic send_frame(input int len, input logic err);
    logic [31:0] w;
    logic [3:0]  k;
    int          lane;
    logic        l;
    w = '0; k = '0; lane = 0;
    for (int i = 0; i < len; i++) begin
      l = (i == len - 1);
      send_byte(frame_buf[i], l, err & l);
      if (expect_en) begin
        w[lane*8 +: 8] = frame_buf[i];
        k[lane]        = 1'b1;
        if (lane == 3 || l) begin
          exp_q.push_back({w, k, l, err & l});
          w = '0; k = '0; lane = 0;
        end else begin
          lane++;
        end
      end
    end
  endtask

  task automatic wait_drain(input int max_cycles);
    for (int i = 0; i < max_cycles && exp_q.size() != 0; i++) @(posedge aclk);
    repeat (4) @(posedge aclk);
    check("drain_pending", 64'(exp_q.size()), 64'(0));
  endtask

  // monitor: a beat is accepted at the next posedge when valid & ready at negedge
  initial begin
    logic [37:0] e;
    forever begin
      @(negedge aclk);
      if (m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("extra_beat", 64'(m_axis_tvalid), 64'(0));
        end else begin
          e = exp_q.pop_front();
          check("beat", 64'({m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser}), 64'(e));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

  initial begin
    int len;
    areset        = 1'b1;
    s_rx_data     = 8'h00;
    s_rx_valid    = 1'b0;
    s_rx_last     = 1'b0;
    s_rx_err      = 1'b0;
    m_axis_tready = 1'b0;
    repeat (3) @(posedge aclk);
    #2;
    check("rst_tvalid", 64'(m_axis_tvalid), 64'(0));
    check("rst_tdata",  64'(m_axis_tdata),  64'(0));
    check("rst_tkeep",  64'(m_axis_tkeep),  64'(0));
    check("rst_tlast",  64'(m_axis_tlast),  64'(0));
    check("rst_tuser",  64'(m_axis_tuser),  64'(0));
    check("rst_ovf",    64'(overflow_cnt),  64'(0));
    areset = 1'b0;

    // 1: frame in progress at reset release is discarded, then a 6-byte frame
    m_axis_tready = 1'b1;
    expect_en = 1'b0;
    frame_buf[0] = 8'hAA; frame_buf[1] = 8'hBB; frame_buf[2] = 8'hCC;
    send_frame(3, 1'b0);
    expect_en = 1'b1;
    for (int i = 0; i < 6; i++) frame_buf[i] = 8'(i + 1);
    send_frame(6, 1'b0);
    idle(2);
    wait_drain(100);

    // 2: single-byte errored frame
    frame_buf[0] = 8'h5A;
    send_frame(1, 1'b1);
    idle(2);
    wait_drain(100);

    // 3: eight bytes with error on last
    for (int i = 0; i < 8; i++) frame_buf[i] = 8'(8'h11 + i);
    send_frame(8, 1'b1);
    idle(2);
    wait_drain(100);

    // random frames, ready held high
    for (int f = 0; f < 8; f++) begin
      len = $urandom_range(13, 1);
      for (int i = 0; i < len; i++) frame_buf[i] = 8'($urandom_range(255, 0));
      send_frame(len, 1'($urandom_range(1, 0)));
      idle($urandom_range(2, 0));
    end
    idle(2);
    wait_drain(200);

    // 4: overflow with tready=0 on a 24-byte frame
    m_axis_tready = 1'b0;
    expect_en = 1'b0;
    for (int i = 0; i < 24; i++) frame_buf[i] = 8'(8'h30 + i);
    send_frame(24, 1'b0);
    for (int w = 0; w < 4; w++) begin
      exp_q.push_back({frame_buf[4*w+3], frame_buf[4*w+2], frame_buf[4*w+1], frame_buf[4*w],
                       4'hF, 1'b0, 1'b0});
    end
    exp_q.push_back({32'h0, 4'h0, 1'b1, 1'b1});
    idle(3);
    check("ovf_cnt_after_overflow", 64'(overflow_cnt), 64'(1));
    @(negedge aclk);
    check("hold_tvalid", 64'(m_axis_tvalid), 64'(1));
    check("hold_head", 64'({m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser}), 64'(exp_q[0]));
    @(posedge aclk);
    #2;
    m_axis_tready = 1'b1;
    wait_drain(100);

    // 5: tready toggling, back-to-back 5-byte frames
    expect_en = 1'b1;
    tog_en    = 1'b1;
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < 5; i++) frame_buf[i] = 8'(8'h50 + 5*f + i);
      send_frame(5, 1'b0);
    end
    tog_en = 1'b0;
    idle(1);
    m_axis_tready = 1'b1;
    wait_drain(100);
    check("ovf_cnt_no_new_overflow", 64'(overflow_cnt), 64'(1));

    // 6: reset mid-frame
    m_axis_tready = 1'b0;
    expect_en = 1'b0;
    for (int i = 0; i < 12; i++) frame_buf[i] = 8'(8'h60 + i);
    for (int i = 0; i < 5; i++) send_byte(frame_buf[i], 1'b0, 1'b0);
    @(posedge aclk);
    #2;
    s_rx_valid = 1'b0;
    areset = 1'b1;
    #1;
    check("midrst_tvalid", 64'(m_axis_tvalid), 64'(0));
    check("midrst_ovf",    64'(overflow_cnt),  64'(0));
    @(posedge aclk);
    #2;
    areset = 1'b0;
    for (int i = 5; i < 12; i++) send_byte(frame_buf[i], (i == 11), 1'b0);
    m_axis_tready = 1'b1;
    idle(4);
    check("post_rst_tvalid", 64'(m_axis_tvalid), 64'(0));
    expect_en = 1'b1;
    for (int i = 0; i < 7; i++) frame_buf[i] = 8'(8'h70 + i);
    send_frame(7, 1'b0);
    idle(2);
    wait_drain(100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
